skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits (legal range 1..64).
REQ-002 Port: aclk  input  1  clock; all state updates on rising edge.
REQ-003 Port: arstn  input  1  reset; asynchronous, active-low.
REQ-004 Port: i_valid  input  1  upstream payload valid.
REQ-005 Port: i_ready  output  1  stage can accept; driven directly from a flop.
REQ-006 Port: i_data  input  DATA_W  upstream payload.
REQ-007 Port: o_valid  output  1  downstream payload valid; driven directly from a flop.
REQ-008 Port: o_ready  input  1  downstream accepts.
REQ-009 Port: o_data  output  DATA_W  downstream payload; driven directly from a flop.
REQ-010 Port: o_count  output  16  accepted-output transfer count; present only under SKID_BUFFER_CNT_EN.

Function
REQ-011 The block SHALL be a 2-entry elastic stage: main register (drives o_data) plus one skid register.
REQ-012 Input transfer SHALL occur on a rising edge with i_valid=1 and i_ready=1; output transfer with o_valid=1 and o_ready=1.
REQ-013 FSM states SHALL be EMPTY (0 entries), BUSY (main full), FULL (main and skid full).
REQ-014 EMPTY: i_ready=1, o_valid=0; input transfer -> BUSY, i_data into main.
REQ-015 BUSY: i_ready=1, o_valid=1; in only -> FULL, i_data into skid; out only -> EMPTY; in and out simultaneously -> stay BUSY, i_data into main.
REQ-016 FULL: i_ready=0, o_valid=1; output transfer -> BUSY, skid moves to main; i_valid ignored.
REQ-017 Latency SHALL be 1 cycle: a word accepted at edge N is on o_data with o_valid=1 after edge N.
REQ-018 Throughput SHALL be 1 word/cycle while o_ready=1 continuously.
REQ-019 Ordering SHALL be strictly FIFO; no word dropped or duplicated.
REQ-020 Once o_valid=1, o_valid and o_data SHALL stay stable until an output transfer.
REQ-021 i_ready SHALL not depend combinationally on o_ready (registered backpressure).
REQ-022 Unreachable state encodings SHALL recover to EMPTY on the next edge.

Reset
REQ-023 While arstn=0: state=EMPTY, o_valid=0, i_ready=0, o_data=0, skid=0, o_count=0.
REQ-024 i_ready SHALL rise to 1 on the first rising edge after arstn deasserts.
REQ-025 Reset mid-operation SHALL discard all held words immediately, without waiting for a clock.

Configuration
REQ-026 Macro SKID_BUFFER_CNT_EN: when defined, o_count SHALL increment by 1 on each output transfer, wrapping 0xFFFF -> 0x0000.
REQ-027 Without SKID_BUFFER_CNT_EN the o_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package skid_buffer_pkg SHALL hold the FSM state enum (EMPTY, BUSY, FULL) and the count width constant (16).
REQ-029 No sub-module; the registers and FSM SHALL be inline in skid_buffer.

Verification
REQ-030 Reset check: arstn=0 for 100 ns -> o_valid=0, i_ready=0, o_data=0; one edge after release -> i_ready=1.
REQ-031 Single word: i_data=0xA5, i_valid=1 for one cycle, o_ready=1 -> o_data=0xA5, o_valid=1 exactly one edge later, then o_valid=0.
REQ-032 Backpressure: o_ready=0, send 0x11 then 0x22 -> i_ready=0 after the second edge; raise o_ready -> outputs 0x11 then 0x22 in order, i_ready returns to 1.
REQ-033 Streaming: o_ready=1, i_valid=1 with 0x00..0x0F on consecutive cycles -> 16 outputs on 16 consecutive cycles, in order, no gaps.
REQ-034 Mid-op reset: reach FULL with 0x33/0x44, pulse arstn=0 between edges -> o_valid=0 immediately; after release no 0x33/0x44 ever emitted.
REQ-035 With SKID_BUFFER_CNT_EN: 70000 output transfers -> o_count=70000 mod 65536=4464.

Source files
------------

// File: rtl/skid_buffer_pkg.sv
// Shared types and constants for the skid buffer elastic stage.
package skid_buffer_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry elastic stage (main + skid register) with fully registered handshake outputs.
// Optional output-transfer counter on o_count when SKID_BUFFER_CNT_EN is defined.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              aclk,
    input  logic              arstn,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              o_ready,
`ifdef SKID_BUFFER_CNT_EN
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count
`else
    output logic [DATA_W-1:0] o_data
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              o_valid_q, o_valid_d;
    logic              i_ready_q, i_ready_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = i_valid & i_ready_q;
    assign out_xfer = o_valid_q & o_ready;

    // Handshake flags are derived from the next state so they leave the flops in step with it.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    main_d  = i_data;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = i_data;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = i_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        o_valid_d = (state_d != EMPTY);
        i_ready_d = (state_d != FULL);
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            o_valid_q <= o_valid_d;
            i_ready_q <= i_ready_d;
        end
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = main_q;

`ifdef SKID_BUFFER_CNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = out_xfer ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Directed, table-driven self-checking bench for skid_buffer (counter test under SKID_BUFFER_CNT_EN).
module tb_skid_buffer;

    localparam int DATA_W = 8;

    logic              aclk;
    logic              arstn;
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
`ifdef SKID_BUFFER_CNT_EN
    logic [15:0]       o_count;
`endif

    int compared;
    int mismatched;

    skid_buffer #(.DATA_W(DATA_W)) dut (
        .aclk    (aclk),
        .arstn   (arstn),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
`ifdef SKID_BUFFER_CNT_EN
        .o_data  (o_data),
        .o_count (o_count)
`else
        .o_data  (o_data)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] din;
        logic              ordy;
        logic              exp_ov;
        logic              exp_ir;
        logic [DATA_W-1:0] exp_od;
        logic              chk_od;
    } vec_t;

    vec_t vecs[13];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic iv, input logic [DATA_W-1:0] din, input logic ordy);
        i_valid = iv;
        i_data  = din;
        o_ready = ordy;
    endtask

    // Advance one edge and leave the outputs settled for sampling.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Single word, backpressure into FULL, then simultaneous in/out in BUSY.
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1};
        vecs[4]  = '{1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1};
        vecs[5]  = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1};
        vecs[8]  = '{1'b1, 8'h6B, 1'b1, 1'b1, 1'b1, 8'h6B, 1'b1};
        vecs[9]  = '{1'b1, 8'h7C, 1'b0, 1'b1, 1'b0, 8'h6B, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h7C, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7C, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};

        arstn = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0);
        #100;
        check_output("reset o_valid", 64'(o_valid), 64'd0);
        check_output("reset i_ready", 64'(i_ready), 64'd0);
        check_output("reset o_data", 64'(o_data), 64'd0);
`ifdef SKID_BUFFER_CNT_EN
        check_output("reset o_count", 64'(o_count), 64'd0);
`endif

        @(negedge aclk);
        arstn = 1'b1;
        check_output("pre-edge i_ready", 64'(i_ready), 64'd0);
        tick();
        check_output("post-release i_ready", 64'(i_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].iv, vecs[i].din, vecs[i].ordy);
            tick();
            check_output($sformatf("vec%0d o_valid", i), 64'(o_valid), 64'(vecs[i].exp_ov));
            check_output($sformatf("vec%0d i_ready", i), 64'(i_ready), 64'(vecs[i].exp_ir));
            if (vecs[i].chk_od) begin
                check_output($sformatf("vec%0d o_data", i), 64'(o_data), 64'(vecs[i].exp_od));
            end
        end

        // Streaming: each word appears one edge after acceptance, one per cycle.
        for (int k = 0; k < 16; k++) begin
            apply_stimulus(1'b1, DATA_W'(k), 1'b1);
            tick();
            check_output($sformatf("stream%0d o_valid", k), 64'(o_valid), 64'd1);
            check_output($sformatf("stream%0d o_data", k), 64'(o_data), 64'(k));
            check_output($sformatf("stream%0d i_ready", k), 64'(i_ready), 64'd1);
        end
        apply_stimulus(1'b0, '0, 1'b1);
        tick();
        check_output("stream drain o_valid", 64'(o_valid), 64'd0);

        // Fill both entries, then reset between edges.
        apply_stimulus(1'b1, 8'h33, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'h44, 1'b0);
        tick();
        check_output("midrst full i_ready", 64'(i_ready), 64'd0);
        check_output("midrst full o_data", 64'(o_data), 64'h33);
        apply_stimulus(1'b0, '0, 1'b0);
        #2;
        arstn = 1'b0;
        #1;
        check_output("midrst o_valid", 64'(o_valid), 64'd0);
        check_output("midrst i_ready", 64'(i_ready), 64'd0);
        check_output("midrst o_data", 64'(o_data), 64'd0);
        #2;
        arstn = 1'b1;
        apply_stimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output($sformatf("postrst%0d o_valid", k), 64'(o_valid), 64'd0);
            check_output($sformatf("postrst%0d i_ready", k), 64'(i_ready), 64'd1);
        end

`ifdef SKID_BUFFER_CNT_EN
        check_output("count after reset", 64'(o_count), 64'd0);
        // 70000 edges of streaming give 69999 transfers; the drain edge makes 70000.
        for (int k = 0; k < 70000; k++) begin
            apply_stimulus(1'b1, DATA_W'(k), 1'b1);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b1);
        tick();
        check_output("count wrap", 64'(o_count), 64'd4464);
        check_output("count drain o_valid", 64'(o_valid), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
